// File: rtl/uart_arb_pkg.sv
// Purpose: shared types and helpers for the UART transmit arbiter and its
//          round-robin picker.
// Contents: FSM state enum and width, requester-index width helper.
package uart_arb_pkg;

   localparam int ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_e;

   // Index width for n requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose:      round-robin picker, first valid at or above ptr, wrapping.
// Latency:      purely combinational, zero cycles.
// Backpressure: none; caller decides whether to act on the winner.
// Ports: req_valid  - one bit per requester
//        ptr        - highest-priority index this round
//        winner     - chosen requester index (0 when found=0)
//        found      - at least one requester is valid
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               found
);

   // Walk the rotated order from farthest to nearest so the requester
   // closest to ptr is the last (and therefore surviving) assignment.
   always_comb begin
      int idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req_valid[idx[IDX_W-1:0]]) begin
            winner = IDX_W'(idx);
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose:      shares one UART transmitter among NUM_REQ byte producers,
//               round-robin, one byte per complete frame.
// Latency:      tx_sending pulses one cycle after acceptance; next grant
//               no earlier than the cycle after tx_busy falls.
// Backpressure: req_ready only in IDLE with the line idle; requesters hold
//               valid/data until accepted.
// Ports: clk, reset_n (synchronous, active-low)
//        req_valid/req_data/req_ready - per-requester handshake, data packed
//                                       FRAME_DATA_LENGTH bits per requester
//        tx_sending/tx_data/tx_busy   - transmitter interface
//        grant_id, active, err_timeout - status
// Optional: define UART_TX_ARB_TIMEOUT_EN to abandon a frame whose busy
//           never rises within START_TIMEOUT cycles (sticky err_timeout).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ           = 4,
   parameter  int FRAME_DATA_LENGTH = 8,
   parameter  int START_TIMEOUT     = 16,
   localparam int IDX_W             = idx_w(NUM_REQ)
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*FRAME_DATA_LENGTH-1:0] req_data,
   output logic [NUM_REQ-1:0]                   req_ready,
   output logic                                 tx_sending,
   output logic [FRAME_DATA_LENGTH-1:0]         tx_data,
   input  logic                                 tx_busy,
   output logic [IDX_W-1:0]                     grant_id,
   output logic                                 active,
   output logic                                 err_timeout
);

   arb_state_e                   state_q, state_d;
   logic [IDX_W-1:0]             ptr_q, ptr_d;
   logic [IDX_W-1:0]             grant_q, grant_d;
   logic [FRAME_DATA_LENGTH-1:0] data_q, data_d;
   logic                         sending_q;
   logic [IDX_W-1:0]             win_idx;
   logic                         win_found;
   logic                         timeout_hit;
   logic [FRAME_DATA_LENGTH-1:0] req_bytes [NUM_REQ];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_bytes[i] = req_data[i*FRAME_DATA_LENGTH +: FRAME_DATA_LENGTH];
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .winner    (win_idx),
      .found     (win_found)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      data_d    = data_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            // reset_n gates the strobe so nothing is handed over while the
            // block is being held in reset.
            if (win_found && !tx_busy && reset_n) begin
               req_ready[win_idx] = 1'b1;
               data_d  = req_bytes[win_idx];
               grant_d = win_idx;
               ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // Only the rise matters here; a low busy just keeps us waiting.
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (timeout_hit) begin
               state_d = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         data_q    <= '0;
         sending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         // Registered pulse that coincides exactly with the LAUNCH cycle.
         sending_q <= (state_d == LAUNCH);
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q;

   // Counter sits at zero outside WAIT_BUSY, so it starts fresh on entry.
   // Timeout fires on the cycle its incremented value reaches START_TIMEOUT.
   always_comb begin
      cnt_d = '0;
      if (state_q == WAIT_BUSY) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (state_q == WAIT_BUSY) && !tx_busy &&
                        (cnt_q == CNT_W'(START_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_q | timeout_hit;
      end
   end

   assign err_timeout = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign tx_sending = sending_q;
   assign tx_data    = data_q;
   assign grant_id   = grant_q;
   assign active     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: directed bench for uart_tx_arbiter with a behavioural transmitter
//          (busy one cycle after sending, FRAME_CYC cycles long) or a
//          hand-driven busy line for the corner-case sequences.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif
   localparam int FRAME_CYC = 10;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_sending;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        active;
   logic        err_timeout;

   logic        auto_tx;
   logic        man_busy;
   logic        model_busy;
   int          mcnt;
   logic [1:0]  log_id[$];
   logic [7:0]  log_byte[$];

   int total;
   int bad;

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] data;
      int          n;
      logic [15:0] eid;    // expected grant order, first in [3:0]
      logic [31:0] ebyte;  // expected byte order, first in [7:0]
   } vec_t;

   vec_t vecs[6];

   assign tx_busy = auto_tx ? model_busy : man_busy;

   uart_tx_arbiter dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_sending  (tx_sending),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant_id    (grant_id),
      .active      (active),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter model: logs every sending pulse; in auto mode it raises
   // busy on the following cycle and holds it for FRAME_CYC cycles.
   initial begin
      logic       snd;
      logic [7:0] d;
      logic [1:0] g;
      model_busy = 1'b0;
      mcnt = 0;
      forever begin
         @(negedge clk);
         snd = tx_sending;
         d   = tx_data;
         g   = grant_id;
         @(posedge clk);
         #1;
         if (mcnt > 0) mcnt--;
         if (snd) begin
            log_id.push_back(g);
            log_byte.push_back(d);
            if (auto_tx) mcnt = FRAME_CYC;
         end
         model_busy = (mcnt != 0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         if (req_valid == 4'b0 && !active && !tx_busy) begin
            done = 1'b1;
            break;
         end
         step();
      end
      check(nm, done, 1'b1);
   endtask

   initial begin
      logic [3:0] acc;
      int         cnt_c3;
      bit         got;
      vec_t       e;

      total = 0;
      bad   = 0;

      vecs[0] = '{4'b1111, 32'h44332211, 4, 16'h3210, 32'h44332211};
      vecs[1] = '{4'b0001, 32'h000000A5, 1, 16'h0000, 32'h000000A5};
      vecs[2] = '{4'b1000, 32'h6A000000, 1, 16'h0003, 32'h0000006A};
      vecs[3] = '{4'b1001, 32'h81000018, 2, 16'h0030, 32'h00008118};
      vecs[4] = '{4'b0110, 32'h00BBAA00, 2, 16'h0021, 32'h0000BBAA};
      vecs[5] = '{4'b0101, 32'h00DD00CC, 2, 16'h0020, 32'h0000DDCC};

      // ---------------- reset state ----------------
      reset_n   = 1'b0;
      auto_tx   = 1'b0;
      man_busy  = 1'b0;
      req_valid = 4'b0001;
      req_data  = 32'h000000A5;
      repeat (3) step();
      @(negedge clk);
      check("rst_ready",   req_ready,   4'b0);
      check("rst_sending", tx_sending,  1'b0);
      check("rst_txdata",  tx_data,     8'h00);
      check("rst_grant",   grant_id,    2'd0);
      check("rst_active",  active,      1'b0);
      check("rst_err",     err_timeout, 1'b0);
      step();
      reset_n   = 1'b1;
      req_valid = 4'b0;
      @(negedge clk);
      check("idle_noreq_ready", req_ready, 4'b0);

      // ---------------- S1: single request, hand-driven busy ----------------
      step();
      req_valid = 4'b0001;
      req_data  = 32'h0000005A;
      @(negedge clk);
      check("s1_ready", req_ready, 4'b0001);
      step();
      req_valid = 4'b0;
      @(negedge clk);
      check("s1_sending", tx_sending, 1'b1);
      check("s1_txdata",  tx_data,    8'h5A);
      check("s1_grant",   grant_id,   2'd0);
      check("s1_active",  active,     1'b1);
      check("s1_ready_launch", req_ready, 4'b0);
      step();
      @(negedge clk);
      check("s1_pulse_once", tx_sending, 1'b0);
      repeat (29) step();
      @(negedge clk);
      check("s1_stall_active", active,      TMO ? 1'b0 : 1'b1);
      check("s1_stall_err",    err_timeout, TMO ? 1'b1 : 1'b0);
      step();
      man_busy  = 1'b1;
      req_valid = 4'b0010;
      req_data  = 32'h0000C300;
      @(negedge clk);
      check("s1_busy_ready0", req_ready, 4'b0);
      repeat (3) step();
      @(negedge clk);
      check("s1_busy_ready1", req_ready, 4'b0);
      step();
      man_busy = 1'b0;
      @(negedge clk);
      check("s1_fall_ready",  req_ready, TMO ? 4'b0010 : 4'b0000);
      check("s1_fall_active", active,    TMO ? 1'b0 : 1'b1);
      step();
      @(negedge clk);
      check("s1_next_ready",  req_ready, TMO ? 4'b0000 : 4'b0010);
      check("s1_next_active", active,    TMO ? 1'b1 : 1'b0);
      step();
      req_valid = 4'b0;
      @(negedge clk);
      check("s2_sending", tx_sending, TMO ? 1'b0 : 1'b1);
      check("s2_txdata",  tx_data,    8'hC3);
      check("s2_grant",   grant_id,   2'd1);

      // ---------------- S2: reset during WAIT_DONE ----------------
      step();
      man_busy  = 1'b1;
      req_valid = 4'b0001;
      req_data  = 32'h00000099;
      step();
      @(negedge clk);
      check("s2_waitdone_active", active, 1'b1);
      step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      @(negedge clk);
      check("s2_rst_active",  active,     1'b0);
      check("s2_rst_ready",   req_ready,  4'b0);
      check("s2_rst_grant",   grant_id,   2'd0);
      check("s2_rst_txdata",  tx_data,    8'h00);
      check("s2_rst_sending", tx_sending, 1'b0);
      repeat (3) step();
      @(negedge clk);
      check("s2_busy_hold_ready", req_ready, 4'b0);
      step();
      man_busy  = 1'b0;
      req_valid = 4'b0;
      repeat (3) step();
      @(negedge clk);
      check("s2_idle_active",  active,     1'b0);
      check("s2_idle_sending", tx_sending, 1'b0);
      cnt_c3 = 0;
      foreach (log_byte[k]) if (log_byte[k] == 8'hC3) cnt_c3++;
      check("s2_log_size",  log_byte.size(), 2);
      check("s2_c3_once",   cnt_c3, 1);

      // ---------------- table: round-robin ordering ----------------
      step();
      auto_tx = 1'b1;
      log_id.delete();
      log_byte.delete();
      for (int v = 0; v < 6; v++) begin
         e = vecs[v];
         step();
         req_data  = e.data;
         req_valid = e.mask;
         got = 1'b0;
         for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (req_valid == 4'b0 && !active && !tx_busy) begin
               got = 1'b1;
               break;
            end
            step();
            req_valid = req_valid & ~acc;
         end
         check($sformatf("v%0d_done", v), got, 1'b1);
         check($sformatf("v%0d_count", v), log_id.size(), e.n);
         for (int k = 0; k < e.n && k < log_id.size(); k++) begin
            check($sformatf("v%0d_id%0d", v, k),   log_id[k],   e.eid[k*4 +: 4]);
            check($sformatf("v%0d_byte%0d", v, k), log_byte[k], e.ebyte[k*8 +: 8]);
         end
         log_id.delete();
         log_byte.delete();
      end

      // ---------------- S3: valid dropped before acceptance ----------------
      step();
      req_valid = 4'b0001;
      req_data  = 32'h00000077;
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (req_ready[0]) begin
            step();
            req_valid = 4'b0010;
            req_data  = 32'h0000EE00;
            got = 1'b1;
            break;
         end
         step();
      end
      check("s3_accept", got, 1'b1);
      repeat (3) step();
      @(negedge clk);
      check("s3_busy_ready", req_ready, 4'b0);
      step();
      req_valid = 4'b0;
      wait_idle("s3_idle");
      repeat (5) step();
      @(negedge clk);
      check("s3_log_size", log_byte.size(), 1);
      if (log_byte.size() > 0) begin
         check("s3_byte", log_byte[0], 8'h77);
      end
      check("s3_active", active, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
